// File: rtl/alu_share_pkg.sv
// alu_share_pkg
//   Shared definitions for the ALU-sharing controller and its arbiter:
//   datapath widths, execute-counter width, FSM state encoding and a
//   helper that converts an execute-cycle count into a counter preload.
package alu_share_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter runs down to zero, so N execute cycles preload N-1.
  function automatic logic [CNT_W-1:0] exec_preload(input int unsigned cycles);
    logic [CNT_W-1:0] load_s;
    load_s = CNT_W'(cycles - 32'd1);
    return load_s;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter, purely combinational. When both inputs
//   are valid the one that did not win last time is chosen; otherwise the
//   single valid input wins.
// Ports:
//   valid        in  2  request valid per input
//   last_grant   in  1  index granted most recently
//   winner       out 1  index of the chosen input
//   winner_valid out 1  at least one input is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       winner,
  output logic       winner_valid
);

  // Winner selection from the valid pattern and the previous grant
  always_comb begin
    winner       = 1'b0;
    winner_valid = 1'b0;
    case (valid)
      2'b01: begin
        winner       = 1'b0;
        winner_valid = 1'b1;
      end
      2'b10: begin
        winner       = 1'b1;
        winner_valid = 1'b1;
      end
      2'b11: begin
        winner       = ~last_grant;
        winner_valid = 1'b1;
      end
      default: begin
        winner       = 1'b0;
        winner_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one external three-operand ALU between two requesters. A request
//   is accepted in IDLE, its operands are held on the ALU for EXEC_CYCLES
//   cycles, the result is captured and offered back to the originator until
//   it is consumed. Round-robin priority alternates under contention.
// Ports:
//   clk, rst                       clock, async active-high reset
//   reqN_valid/ready               request handshake, N = 0, 1
//   reqN_a/b/c, reqN_op            request operands and opcode
//   rspN_valid/ready               response handshake
//   rspN_r, rspN_cout              captured result (shared by both ports)
//   alu_a/b/c, alu_op              registered operands to the shared ALU
//   alu_r, alu_cout                combinational ALU result
//   busy                           controller is not idle
module alu_share_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0_valid,
  output logic                           req0_ready,
  input  logic [DATA_W-1:0]              req0_a,
  input  logic [DATA_W-1:0]              req0_b,
  input  logic [DATA_W-1:0]              req0_c,
  input  logic [alu_share_pkg::OP_W-1:0] req0_op,
  input  logic                           req1_valid,
  output logic                           req1_ready,
  input  logic [DATA_W-1:0]              req1_a,
  input  logic [DATA_W-1:0]              req1_b,
  input  logic [DATA_W-1:0]              req1_c,
  input  logic [alu_share_pkg::OP_W-1:0] req1_op,
  output logic                           rsp0_valid,
  input  logic                           rsp0_ready,
  output logic [DATA_W-1:0]              rsp0_r,
  output logic                           rsp0_cout,
  output logic                           rsp1_valid,
  input  logic                           rsp1_ready,
  output logic [DATA_W-1:0]              rsp1_r,
  output logic                           rsp1_cout,
  output logic [DATA_W-1:0]              alu_a,
  output logic [DATA_W-1:0]              alu_b,
  output logic [DATA_W-1:0]              alu_c,
  output logic [alu_share_pkg::OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]              alu_r,
  input  logic                           alu_cout,
  output logic                           busy
);

  import alu_share_pkg::*;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              grant_id_r;
  logic              last_grant_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [DATA_W-1:0] alu_c_r;
  logic [OP_W-1:0]   alu_op_r;
  logic [DATA_W-1:0] result_r;
  logic              result_cout_r;
  logic [1:0]        rsp_valid_r;
  logic              busy_r;

  logic [1:0]        req_valid_s;
  logic              win_s;
  logic              win_valid_s;
  logic [1:0]        ready_s;
  logic              accept_s;
  logic              cnt_zero_s;
  logic              capture_s;
  logic              rsp_done_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [DATA_W-1:0] sel_c_s;
  logic [OP_W-1:0]   sel_op_s;

  assign req_valid_s = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid        (req_valid_s),
    .last_grant   (last_grant_r),
    .winner       (win_s),
    .winner_valid (win_valid_s)
  );

  // Ready is offered only to the arbitration winner while idle; held low in reset
  always_comb begin
    ready_s = 2'b00;
    if ((state_r == IDLE) && win_valid_s && !rst) begin
      if (win_s) begin
        ready_s = 2'b10;
      end else begin
        ready_s = 2'b01;
      end
    end else begin
      ready_s = 2'b00;
    end
  end

  assign accept_s   = |(ready_s & req_valid_s);
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
  assign capture_s  = (state_r == EXEC) && cnt_zero_s;

  // Response completes when the owning requester takes the result
  always_comb begin
    rsp_done_s = 1'b0;
    if (state_r == RESP) begin
      if (grant_id_r) begin
        rsp_done_s = rsp1_ready;
      end else begin
        rsp_done_s = rsp0_ready;
      end
    end else begin
      rsp_done_s = 1'b0;
    end
  end

  // Operand mux selecting the winner's request fields
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_c_s  = req0_c;
    sel_op_s = req0_op;
    if (win_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_c_s  = req1_c;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_c_s  = req0_c;
      sel_op_s = req0_op;
    end
  end

  // Next-state logic for the IDLE/EXEC/RESP sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_zero_s) begin
          state_s = RESP;
        end else begin
          state_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand and grant capture on the request handshake; held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r      <= {DATA_W{1'b0}};
      alu_b_r      <= {DATA_W{1'b0}};
      alu_c_r      <= {DATA_W{1'b0}};
      alu_op_r     <= {OP_W{1'b0}};
      grant_id_r   <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      alu_a_r      <= sel_a_s;
      alu_b_r      <= sel_b_s;
      alu_c_r      <= sel_c_s;
      alu_op_r     <= sel_op_s;
      grant_id_r   <= win_s;
      last_grant_r <= win_s;
    end
  end

  // Execute counter: preloaded on accept, counts down while executing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_r <= exec_preload(EXEC_CYCLES);
    end else if ((state_r == EXEC) && !cnt_zero_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  // Result capture in the last execute cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r      <= {DATA_W{1'b0}};
      result_cout_r <= 1'b0;
    end else if (capture_s) begin
      result_r      <= alu_r;
      result_cout_r <= alu_cout;
    end
  end

  // Registered response-valid and busy flags, aligned with the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      if (capture_s) begin
        rsp_valid_r <= grant_id_r ? 2'b10 : 2'b01;
      end else if (rsp_done_s) begin
        rsp_valid_r <= 2'b00;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (rsp_done_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign req0_ready = ready_s[0];
  assign req1_ready = ready_s[1];
  assign rsp0_valid = rsp_valid_r[0];
  assign rsp1_valid = rsp_valid_r[1];
  assign rsp0_r     = result_r;
  assign rsp1_r     = result_r;
  assign rsp0_cout  = result_cout_r;
  assign rsp1_cout  = result_cout_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_c      = alu_c_r;
  assign alu_op     = alu_op_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
//   Two controller instances (EXEC_CYCLES = 1 and 3), each with a bench ALU.
//   A transaction-level reference model predicts ready, response, busy and
//   ALU-operand values every cycle from arbitration rules and event times.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // stimulus, indexed [dut][requester]
  logic       st_v  [2][2];
  logic [7:0] st_a  [2][2];
  logic [7:0] st_b  [2][2];
  logic [7:0] st_c  [2][2];
  logic [1:0] st_op [2][2];
  logic       st_rr [2][2];

  // observed outputs
  logic       o_rdy  [2][2];
  logic       o_rspv [2][2];
  logic [7:0] o_r    [2][2];
  logic       o_cout [2][2];
  logic [7:0] o_alu_a [2];
  logic [7:0] o_alu_b [2];
  logic [7:0] o_alu_c [2];
  logic [1:0] o_alu_op [2];
  logic [7:0] o_alu_r [2];
  logic       o_alu_cout [2];
  logic       o_busy [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // bench ALU: 0 a+b, 1 a+b+c, 2 a^b^c, 3 a-b (cout = borrow)
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [1:0] op);
    logic [9:0] s;
    case (op)
      2'd0:    s = {2'b00, a} + {2'b00, b};
      2'd1:    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
      2'd2:    s = {2'b00, a ^ b ^ c};
      default: s = {2'b00, a} - {2'b00, b};
    endcase
    return s[8:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_share_ctrl #(.EXEC_CYCLES((g == 0) ? 1 : 3), .DATA_W(8)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(st_v[g][0]), .req0_ready(o_rdy[g][0]),
      .req0_a(st_a[g][0]), .req0_b(st_b[g][0]), .req0_c(st_c[g][0]), .req0_op(st_op[g][0]),
      .req1_valid(st_v[g][1]), .req1_ready(o_rdy[g][1]),
      .req1_a(st_a[g][1]), .req1_b(st_b[g][1]), .req1_c(st_c[g][1]), .req1_op(st_op[g][1]),
      .rsp0_valid(o_rspv[g][0]), .rsp0_ready(st_rr[g][0]), .rsp0_r(o_r[g][0]), .rsp0_cout(o_cout[g][0]),
      .rsp1_valid(o_rspv[g][1]), .rsp1_ready(st_rr[g][1]), .rsp1_r(o_r[g][1]), .rsp1_cout(o_cout[g][1]),
      .alu_a(o_alu_a[g]), .alu_b(o_alu_b[g]), .alu_c(o_alu_c[g]), .alu_op(o_alu_op[g]),
      .alu_r(o_alu_r[g]), .alu_cout(o_alu_cout[g]),
      .busy(o_busy[g])
    );
    assign {o_alu_cout[g], o_alu_r[g]} = alu_fn(o_alu_a[g], o_alu_b[g], o_alu_c[g], o_alu_op[g]);
  end

  // reference model state per dut
  bit          m_infl [2];
  int          m_acc  [2];
  bit          m_gid  [2];
  bit          m_last [2];
  logic [8:0]  m_res  [2];
  logic [8:0]  m_shown [2];
  logic [25:0] m_alu  [2];
  bit   [1:0]  m_took [2];
  int          obs0 [$];
  int          obs1 [$];

  function automatic int ecyc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic string tg(input string s, input int d);
    return $sformatf("%s_d%0d", s, d);
  endfunction

  function automatic int obs_at(input int d, input int i);
    if (d == 0) return (obs0.size() > i) ? obs0[i] : -1;
    return (obs1.size() > i) ? obs1[i] : -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_infl[d] = 1'b0; m_acc[d] = 0; m_gid[d] = 1'b0; m_last[d] = 1'b1;
      m_res[d] = 9'd0; m_shown[d] = 9'd0; m_alu[d] = 26'd0; m_took[d] = 2'b00;
    end
  endtask

  // compare every output against the model, then advance the model
  task automatic check_model();
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [1:0] erdy;
      logic [1:0] ersp;
      bit w;
      bit wv;
      bit rsp_on;
      erdy = 2'b00; ersp = 2'b00; w = 1'b0; wv = 1'b0;
      if (!rst && !m_infl[d]) begin
        if (st_v[d][0] && st_v[d][1]) begin w = !m_last[d]; wv = 1'b1; end
        else if (st_v[d][0]) begin w = 1'b0; wv = 1'b1; end
        else if (st_v[d][1]) begin w = 1'b1; wv = 1'b1; end
        if (wv) erdy[w] = 1'b1;
      end
      rsp_on = m_infl[d] && (cyc > m_acc[d] + ecyc(d));
      if (rsp_on) begin
        m_shown[d] = m_res[d];
        ersp[m_gid[d]] = 1'b1;
      end
      for (int r = 0; r < 2; r++) begin
        if (o_rdy[d][r] && st_v[d][r]) begin
          if (d == 0) obs0.push_back(r); else obs1.push_back(r);
        end
      end
      chk(tg("ready", d), 32'({o_rdy[d][1], o_rdy[d][0]}), 32'(erdy));
      chk(tg("rsp_valid", d), 32'({o_rspv[d][1], o_rspv[d][0]}), 32'(ersp));
      chk(tg("busy", d), 32'(o_busy[d]), 32'(m_infl[d]));
      chk(tg("rsp0_data", d), 32'({o_cout[d][0], o_r[d][0]}), 32'(m_shown[d]));
      chk(tg("rsp1_data", d), 32'({o_cout[d][1], o_r[d][1]}), 32'(m_shown[d]));
      chk(tg("alu_regs", d), 32'({o_alu_op[d], o_alu_a[d], o_alu_b[d], o_alu_c[d]}), 32'(m_alu[d]));
      if (!rst) begin
        if (wv) begin
          m_infl[d] = 1'b1; m_acc[d] = cyc; m_gid[d] = w; m_last[d] = w;
          m_alu[d] = {st_op[d][w], st_a[d][w], st_b[d][w], st_c[d][w]};
          m_res[d] = alu_fn(st_a[d][w], st_b[d][w], st_c[d][w], st_op[d][w]);
          m_took[d][w] = 1'b1;
        end else if (rsp_on && st_rr[d][m_gid[d]]) begin
          m_infl[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    check_model();
    tick();
  endtask

  task automatic load(input int d, input int r, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [1:0] op);
    st_v[d][r] = 1'b1; st_a[d][r] = a; st_b[d][r] = b; st_c[d][r] = c; st_op[d][r] = op;
  endtask

  task automatic load_rand(input int d, input int r);
    load(d, r, 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom));
  endtask

  // after an accept the requester drops valid, or issues a fresh request
  task automatic react(input bit renew);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (m_took[d][r]) begin
          m_took[d][r] = 1'b0;
          if (renew) load_rand(d, r); else st_v[d][r] = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(input int n);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        st_v[d][r] = 1'b0; st_rr[d][r] = 1'b1;
      end
    end
    for (int i = 0; i < n; i++) begin
      step();
      react(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    check_model();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        st_v[d][r] = 1'b0; st_a[d][r] = 8'd0; st_b[d][r] = 8'd0;
        st_c[d][r] = 8'd0; st_op[d][r] = 2'd0; st_rr[d][r] = 1'b1;
      end
    end
    model_reset();
    // reset state
    check_model();
    chk("reset_busy", 32'(o_busy[0]), 32'd0);
    tick();
    do_reset();

    // single request on the 1-cycle instance: 200 + 100 = 300 -> r 44, cout 1
    load(0, 0, 8'd200, 8'd100, 8'd0, 2'd0);
    check_model();
    chk("single_ready", 32'(o_rdy[0][0]), 32'd1);
    tick();
    react(1'b0);
    step();
    check_model();
    chk("single_rsp0_valid", 32'(o_rspv[0][0]), 32'd1);
    chk("single_r", 32'(o_r[0][0]), 32'd44);
    chk("single_cout", 32'(o_cout[0][0]), 32'd1);
    chk("single_rsp1_valid", 32'(o_rspv[0][1]), 32'd0);
    tick();
    drain(3);

    // contention right after reset: requester 0 first
    do_reset();
    obs0.delete();
    load_rand(0, 0);
    load_rand(0, 1);
    for (int i = 0; i < 20 && (obs0.size() < 2 || m_infl[0]); i++) begin
      step();
      react(1'b0);
    end
    chk("contend_count", 32'(obs0.size()), 32'd2);
    chk("contend_first", 32'(obs_at(0, 0)), 32'd0);
    chk("contend_second", 32'(obs_at(0, 1)), 32'd1);

    // back-to-back alternation for six operations
    obs0.delete();
    load_rand(0, 0);
    load_rand(0, 1);
    for (int i = 0; i < 100 && obs0.size() < 6; i++) begin
      step();
      react(obs0.size() < 6);
    end
    drain(6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_grant%0d", i), 32'(obs_at(0, i)), 32'(i % 2));
    end

    // backpressure on the 3-cycle instance
    obs1.delete();
    st_rr[1][1] = 1'b0;
    load_rand(1, 1);
    step();
    react(1'b0);
    load_rand(1, 0);
    for (int i = 0; i < 10 && !(m_infl[1] && (cyc > m_acc[1] + 3)); i++) step();
    for (int i = 0; i < 5; i++) begin
      check_model();
      chk("bp_rsp1_valid", 32'(o_rspv[1][1]), 32'd1);
      chk("bp_no_ready0", 32'(o_rdy[1][0]), 32'd0);
      tick();
    end
    st_rr[1][1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      react(1'b0);
    end
    chk("bp_order", 32'(obs_at(1, 0) * 2 + obs_at(1, 1)), 32'd2);

    // reset in the middle of execute
    load_rand(1, 0);
    step();
    react(1'b0);
    step();
    rst = 1'b1;
    model_reset();
    check_model();
    chk("mid_rst_busy", 32'(o_busy[1]), 32'd0);
    chk("mid_rst_alu_a", 32'(o_alu_a[1]), 32'd0);
    chk("mid_rst_rsp", 32'({o_rspv[1][1], o_rspv[1][0]}), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    obs1.delete();
    load_rand(1, 0);
    load_rand(1, 1);
    for (int i = 0; i < 30 && (obs1.size() < 2 || m_infl[1]); i++) begin
      step();
      react(1'b0);
    end
    chk("post_rst_first", 32'(obs_at(1, 0)), 32'd0);
    chk("post_rst_second", 32'(obs_at(1, 1)), 32'd1);

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          if (!st_v[d][r] && ($urandom_range(2) == 0)) load_rand(d, r);
          st_rr[d][r] = 1'(($urandom_range(3)) != 0);
        end
      end
      step();
      react(1'b0);
    end
    drain(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
